add_4bit_serial: RTL
====================

// Module: add_4bit_serial
// PURPOSE
//  Bit-serial two's-complement adder; complement of the combinational subtractor.
//  Captures two operands on a valid/ready handshake and adds one bit per cycle, LSB first.
//  Returns sum, carry-out and signed overflow on a valid/ready output handshake.
//  Sits in the datapath test harness where area matters more than latency.
// PARAMETERS
//  WIDTH  4  operand/sum width in bits (>=2)
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      operands a/b valid
//  in_ready   out  1      block can accept operands
//  a          in   WIDTH  operand A (two's complement)
//  b          in   WIDTH  operand B (two's complement)
//  out_valid  out  1      sum/carry/overflow valid
//  out_ready  in   1      consumer accepts result
//  sum        out  WIDTH  a+b modulo 2^WIDTH
//  carry      out  1      unsigned carry-out of MSB
//  overflow   out  1      signed overflow
// BEHAVIOUR
//  - One clock (clk); reset synchronous active-high (rst): rst=1 at an edge forces IDLE.
//  - Reset values: in_ready=1, out_valid=0, sum=0, carry=0, overflow=0.
//  - Reset takes effect at any time, including mid-RUN or mid-DONE; the in-flight operation
//    is discarded and produces no output.
//  - FSM has three states: IDLE, RUN and DONE.
//  - IDLE: in_ready=1 and out_valid=0.
//    On in_valid&&in_ready:
//      - latch a and b into shift registers;
//      - clear the internal carry and the bit counter (cnt=0);
//      - go to RUN.
//  - RUN: in_ready=0. Each cycle, a full-adder cell combines a_sh[0], b_sh[0] and carry:
//      - the sum bit enters the result shift register at the MSB end (shift right);
//      - the carry register updates;
//      - cnt increments.
//    When cnt==WIDTH-1, this cycle's bit completes the sum; go to DONE.
//  - Latency: out_valid rises exactly WIDTH cycles after the accepting edge (4 for default).
//  - DONE: out_valid=1, and sum/carry/overflow are held stable until out_ready.
//    On out_valid&&out_ready, go to IDLE. in_ready rises the following cycle.
//    A new operand is never accepted on the same edge as the result handshake.
//  - Throughput: one operation per WIDTH+2 cycles with out_ready tied high.
//  - in_valid, a and b are ignored outside IDLE; later changes do not affect the captured operands.
//  - out_ready is ignored outside DONE.
//  - carry = final carry register.
//  - overflow = (a[W-1]==b[W-1]) && (sum[W-1]!=a[W-1]), using the captured operand MSBs
//    held in dedicated flops.
// CONFIGURATION
//  ADD_SATURATE_EN defined:
//    - when overflow=1, sum is clamped: a[W-1]=0 gives 0111..1; a[W-1]=1 gives 1000..0;
//    - overflow and carry still report the raw (unclamped) result.
//  ADD_SATURATE_EN undefined: sum wraps modulo 2^WIDTH.
// STRUCTURE
//  - Package add_serial_pkg holds:
//      - the state typedef (IDLE/RUN/DONE);
//      - the localparam for counter width, $clog2(WIDTH).
//  - Sub-module full_adder_cell (a, b, cin -> s, cout) is purely combinational and
//    instantiated once.
//  - FSM, shift registers, counter and saturation logic live in the top module.
// TESTING
//  - a=3, b=4 -> after 4 cycles: sum=7, carry=0, overflow=0.
//  - a=7, b=1 -> sum=8 (1000), overflow=1, carry=0.
//    With ADD_SATURATE_EN: sum=7 (0111), overflow=1.
//  - a=15, b=1 (-1+1) -> sum=0, carry=1, overflow=0.
//    a=8, b=8 -> sum=0, carry=1, overflow=1 (saturated: 1000).
//  - Backpressure:
//    - hold out_ready=0 for 3 cycles in DONE -> out_valid stays 1 and outputs stay stable;
//    - in_valid=1 with new a/b during RUN/DONE -> ignored, result unchanged.
//  - Reset: assert rst at cnt==2 of a RUN -> next cycle in_ready=1, out_valid=0,
//    all outputs 0; the next operation a=2, b=5 yields 7.
//  - Random: 1000 back-to-back random a/b with random out_ready, checked against a+b.

Source files
------------

// File: rtl/add_serial_pkg.sv
// Shared types and constants for the bit-serial adder.
package add_serial_pkg;

  // Operand width of the default build.
  localparam int unsigned AddWidth = 4;

  // Bit counter width for the default build. The counter only has to reach AddWidth-1.
  localparam int unsigned CntWidth = $clog2(AddWidth);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } add_state_e;

endpackage

// File: rtl/full_adder_cell.sv
// Single-bit full adder. This is the only arithmetic in the serial adder.
module full_adder_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic s_o,
  output logic cout_o
);

  // Sum and carry of one bit position.
  always_comb begin
    s_o    = a_i ^ b_i ^ cin_i;
    cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));
  end

endmodule

// File: rtl/add_4bit_serial.sv
// Bit-serial two's-complement adder, LSB first, one bit per clock.
// Operands arrive on a valid/ready handshake. The result leaves on a second valid/ready handshake.
// Optional build macro ADD_SATURATE_EN clamps sum on signed overflow. The carry and
// overflow outputs still report the raw result.
module add_4bit_serial
  import add_serial_pkg::*;
#(
  parameter int unsigned WIDTH = AddWidth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  // The package constant covers the default width. Other widths derive their own.
  localparam int unsigned CntW = (WIDTH == AddWidth) ? CntWidth : $clog2(WIDTH);

  add_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;

  logic             fa_s;
  logic             fa_cout;
  logic             ovf;

  full_adder_cell u_fa (
    .a_i    (a_sh_q[0]),
    .b_i    (b_sh_q[0]),
    .cin_i  (carry_q),
    .s_o    (fa_s),
    .cout_o (fa_cout)
  );

  // Next-state, datapath updates and handshake outputs.
  always_comb begin
    state_d   = state_q;
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    res_d     = res_q;
    carry_d   = carry_q;
    cnt_d     = cnt_q;
    a_msb_d   = a_msb_q;
    b_msb_d   = b_msb_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_sh_d  = a;
          b_sh_d  = b;
          // The MSBs are kept separately because the shift registers drain during RUN.
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
          carry_d = 1'b0;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
        res_d   = {fa_s, res_q[WIDTH-1:1]};
        carry_d = fa_cout;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CntW'(WIDTH - 1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        out_valid = 1'b1;
        // The edge that accepts the result returns to IDLE, so no operand is taken on that edge.
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Result outputs, with optional clamping on signed overflow.
  always_comb begin
    ovf      = (a_msb_q == b_msb_q) && (res_q[WIDTH-1] != a_msb_q);
    overflow = ovf;
    carry    = carry_q;
    sum      = res_q;
`ifdef ADD_SATURATE_EN
    if (ovf) begin
      sum = a_msb_q ? {1'b1, {(WIDTH - 1){1'b0}}} : {1'b0, {(WIDTH - 1){1'b1}}};
    end
`endif
  end

  // State and datapath registers. Synchronous reset discards any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
    end
  end

endmodule
